// File: rtl/uart_rx_fifo_if.sv
// Avalon-MM read-only slave bundle plus interrupt line for the UART receive FIFO.
// The slave modport is the peripheral side; the master modport is the CPU side.
interface uart_rx_fifo_if;
    logic        avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;

    modport slave (
        input  avs_address,
        input  avs_read,
        output avs_readdata,
        output irq
    );

    modport master (
        output avs_address,
        output avs_read,
        input  avs_readdata,
        input  irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 oversampling UART receiver feeding a byte FIFO that a CPU drains over
// a read-only Avalon-MM slave (DATA at address 0, STATUS at address 1).
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rxd,
    uart_rx_fifo_if.slave  avs
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detection
    // ------------------------------------------------------------------
    logic       rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic [1:0] fill_q, fill_d;
    logic       line_ready;
    logic       fall;

    // The flops reset to the idle level, so edges are ignored until they hold
    // genuinely sampled data; a line already low at release is no start bit.
    assign line_ready = (fill_q == 2'd3);
    assign fall       = line_ready && rxd_prev_q && !rxd_s_q;
    assign fill_d     = line_ready ? fill_q : fill_q + 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
            fill_q     <= 2'd0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
            fill_q     <= fill_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             frame_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line reports one frame error, not one per bit time.
                cnt_d = '0;
                if (rxd_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO, sticky flags and register read port
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          irq_q, irq_d;

    logic          full, empty;
    logic          data_rd, status_rd;
    logic          pop, push_ok, overrun_evt;
    logic [31:0]   status_word;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign data_rd     = avs.avs_read && !avs.avs_address;
    assign status_rd   = avs.avs_read &&  avs.avs_address;
    assign pop         = data_rd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push_ok     = push_q && (!full || pop);
    assign overrun_evt = push_q && full && !pop;
    assign status_word = {20'b0, frame_err_q, overrun_q, full, empty, 3'b0, 5'(count_q)};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        readdata_d  = readdata_q;
        irq_d       = !empty;
        // A sticky event coinciding with the clearing read keeps the flag set.
        overrun_d   = overrun_evt || (overrun_q   && !status_rd);
        frame_err_d = frame_evt   || (frame_err_q && !status_rd);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (data_rd) begin
            readdata_d = empty ? 32'd0 : {23'b0, 1'b1, mem[rd_ptr_q]};
        end else if (status_rd) begin
            readdata_d = status_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            readdata_q  <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign avs.irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven on rxd and a
// queue-based model of the FIFO and sticky flags predicts every register read.
module tb_uart_rx_fifo;

    localparam int TB_CLK_HZ = 1600000;
    localparam int TB_BAUD   = 100000;
    localparam int CPB       = TB_CLK_HZ / TB_BAUD;
    localparam int HALF      = CPB / 2;
    localparam int DEPTH     = 16;
    // Start edge to push cycle: two synchroniser stages, one edge-detect cycle,
    // mid-stop-bit sample, then the push one cycle after that sample.
    localparam int PUSH_OFS  = HALF + 9 * CPB + 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rxd     = 1'b1;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .CLK_HZ     (TB_CLK_HZ),
        .BAUD       (TB_BAUD),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rxd     (rxd),
        .avs     (bus.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [7:0] model_q[$];
    bit         model_ovr;
    bit         model_fe;

    function automatic logic [31:0] exp_status();
        return {20'b0, model_fe, model_ovr, model_q.size() == DEPTH,
                model_q.size() == 0, 3'b0, 5'(model_q.size())};
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (model_q.size() == DEPTH) model_ovr = 1'b1;
        else model_q.push_back(b);
    endfunction

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
    endtask

    task automatic avs_rd(input logic a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        bus.avs_address = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        if (bus.avs_readdata !== 32'd0) $display("FAIL reset_readdata: got %h expected %h", bus.avs_readdata, 32'd0);
        else passed++;
        total++;
        if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus.irq);
        else passed++;
        total++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        avs_rd(1'b1, got);
        if (got !== 32'h100) $display("FAIL reset_status: got %h expected %h", got, 32'h100);
        else passed++;
        total++;
        $display("reset: status %h", got);
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        logic [31:0] got, exp;
        send_frame(b);
        model_rx(b);
        if (bus.irq !== 1'b1) $display("FAIL single_irq_set: got %b expected 1", bus.irq);
        else passed++;
        total++;
        exp = exp_status();
        avs_rd(1'b1, got);
        model_ovr = 0; model_fe = 0;
        if (got !== exp) $display("FAIL single_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        exp = {23'b0, 1'b1, model_q.pop_front()};
        avs_rd(1'b0, got);
        if (got !== exp) $display("FAIL single_data: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("single frame %h: data %h", b, got);
        @(negedge clk);
        avs_rd(1'b0, got);
        if (got !== 32'd0) $display("FAIL single_empty_data: got %h expected %h", got, 32'd0);
        else passed++;
        total++;
        if (bus.irq !== 1'b0) $display("FAIL single_irq_clear: got %b expected 0", bus.irq);
        else passed++;
        total++;
    endtask

    task automatic test_random_frames();
        logic [31:0] got, exp;
        logic [7:0]  b;
        int          n;
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            send_frame(b);
            model_rx(b);
        end
        if (bus.irq !== 1'b1) $display("FAIL burst_irq: got %b expected 1", bus.irq);
        else passed++;
        total++;
        exp = exp_status();
        avs_rd(1'b1, got);
        model_ovr = 0; model_fe = 0;
        if (got !== exp) $display("FAIL burst_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        while (model_q.size() > 0) begin
            exp = {23'b0, 1'b1, model_q.pop_front()};
            avs_rd(1'b0, got);
            if (got !== exp) $display("FAIL burst_data: got %h expected %h", got, exp);
            else passed++;
            total++;
            $display("burst read: data %h", got);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] got, exp;
        int          len;
        len = $urandom_range(1, HALF - 3);
        rxd = 1'b0;
        repeat (len) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp = exp_status();
        avs_rd(1'b1, got);
        if (got !== exp) $display("FAIL glitch_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("glitch %0d cycles: status %h", len, got);
    endtask

    task automatic test_framing(input logic [7:0] b, input int held_bits);
        logic [31:0] got, exp;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rxd = 1'b0;
        repeat (held_bits * CPB) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);
        model_fe = 1'b1;
        exp = exp_status();
        avs_rd(1'b1, got);
        model_ovr = 0; model_fe = 0;
        if (got !== exp) $display("FAIL framing_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        exp = exp_status();
        avs_rd(1'b1, got);
        if (got !== exp) $display("FAIL framing_cleared: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("framing %h held %0d bits: status after clear %h", b, held_bits, got);
    endtask

    task automatic test_overrun();
        logic [31:0] got, exp;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i));
            model_rx(8'(i));
        end
        exp = exp_status();
        avs_rd(1'b1, got);
        model_ovr = 0; model_fe = 0;
        if (got !== exp) $display("FAIL overrun_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("overrun: status %h", got);
        exp = exp_status();
        avs_rd(1'b1, got);
        if (got !== exp) $display("FAIL overrun_cleared: got %h expected %h", got, exp);
        else passed++;
        total++;
        while (model_q.size() > 0) begin
            exp = {23'b0, 1'b1, model_q.pop_front()};
            avs_rd(1'b0, got);
            if (got !== exp) $display("FAIL overrun_data: got %h expected %h", got, exp);
            else passed++;
            total++;
        end
        avs_rd(1'b0, got);
        if (got !== 32'd0) $display("FAIL overrun_drained: got %h expected %h", got, 32'd0);
        else passed++;
        total++;
    endtask

    task automatic test_collision_sticky();
        logic [31:0] got, exp;
        logic [7:0]  b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b);
            model_rx(b);
        end
        // Data read lands in the exact push cycle of the 17th byte.
        b = 8'($urandom);
        exp = {23'b0, 1'b1, model_q.pop_front()};
        model_rx(b);
        fork
            send_frame(b);
            begin
                repeat (PUSH_OFS) @(negedge clk);
                avs_rd(1'b0, got);
            end
        join
        if (got !== exp) $display("FAIL collision_data: got %h expected %h", got, exp);
        else passed++;
        total++;
        exp = exp_status();
        avs_rd(1'b1, got);
        if (got !== exp) $display("FAIL collision_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("collision: status %h", got);
        // Status read lands in the cycle a byte is dropped: the flag must survive.
        b = 8'($urandom);
        exp = exp_status();
        fork
            send_frame(b);
            begin
                repeat (PUSH_OFS) @(negedge clk);
                avs_rd(1'b1, got);
            end
        join
        model_rx(b);
        if (got !== exp) $display("FAIL sticky_read: got %h expected %h", got, exp);
        else passed++;
        total++;
        exp = exp_status();
        avs_rd(1'b1, got);
        model_ovr = 0; model_fe = 0;
        if (got !== exp) $display("FAIL sticky_kept: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("sticky: status %h", got);
        while (model_q.size() > 0) begin
            exp = {23'b0, 1'b1, model_q.pop_front()};
            avs_rd(1'b0, got);
            if (got !== exp) $display("FAIL collision_order: got %h expected %h", got, exp);
            else passed++;
            total++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] got, exp;
        logic [7:0]  b;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_frame(b);
            model_rx(b);
        end
        avs_rd(1'b1, got);
        b = 8'($urandom);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        repeat (HALF) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovr = 0; model_fe = 0;
        if (bus.avs_readdata !== 32'd0) $display("FAIL areset_readdata: got %h expected %h", bus.avs_readdata, 32'd0);
        else passed++;
        total++;
        if (bus.irq !== 1'b0) $display("FAIL areset_irq: got %b expected 0", bus.irq);
        else passed++;
        total++;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(1'b1);
        exp = exp_status();
        avs_rd(1'b1, got);
        if (got !== exp) $display("FAIL areset_status: got %h expected %h", got, exp);
        else passed++;
        total++;
        send_frame(8'h55);
        model_rx(8'h55);
        exp = {23'b0, 1'b1, model_q.pop_front()};
        avs_rd(1'b0, got);
        if (got !== exp) $display("FAIL areset_recover: got %h expected %h", got, exp);
        else passed++;
        total++;
        $display("async reset: recovered data %h", got);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

    initial begin
        bus.avs_address = 1'b0;
        bus.avs_read    = 1'b0;
        model_ovr = 0;
        model_fe  = 0;
        @(negedge clk);
        test_reset();
        test_single_frame(8'hA5);
        test_single_frame(8'($urandom));
        test_random_frames();
        test_glitch();
        test_framing(8'h3C, 2);
        test_framing(8'($urandom), $urandom_range(2, 5));
        test_overrun();
        test_collision_sticky();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
